ace_rle_encoder: RTL and testbench

- Snapshot saver for the Jupiter Ace core: reads a RAM region and emits a byte stream in .ACE compressed format, so it can be uploaded to the HPS as a file.
- Output is exactly the format the existing .ACE loader consumes:
  - literal bytes;
  - run escape ED, count, value;
  - terminator ED 00.
- Sits between the ace memory arbiter (read port) and the hps_io upload path (byte valid/ready stream).

---
 rtl/ace_rle_encoder.sv | 257 +++++++++++++++++++++++++
 tb/tb_ace_rle_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_rle_encoder.sv
// ace_rle_encoder: reads a RAM region and streams it out in .ACE compressed form
// (literals, ED count value escapes, ED 00 terminator).
module ace_rle_encoder #(
    parameter logic [15:0] START_ADDR = 16'h2000,
    parameter logic [15:0] END_ADDR   = 16'hFFFF,
    parameter int unsigned MIN_RUN    = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_count
);

    localparam int unsigned AW = 17;
    localparam int unsigned MW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 17;
    localparam logic [DW-1:0] ESC     = 8'hED;
    localparam logic [DW-1:0] RUN_MAX = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        READ,
        WAIT,
        CMP,
        FLUSH_LIT,
        FLUSH_ESC0,
        FLUSH_ESC1,
        FLUSH_ESC2,
        TERM0,
        TERM1,
        DONE
    } state_t;

    state_t          state_q, state_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   byte_q, byte_n;
    logic [DW-1:0]   run_val_q, run_val_n;
    logic [DW-1:0]   run_len_q, run_len_n;
    logic            final_q, final_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic [MW-1:0]   mem_addr_q, mem_addr_n;
    logic            mem_rd_q, mem_rd_n;
    logic [DW-1:0]   out_data_q, out_data_n;
    logic            out_valid_q, out_valid_n;
    logic [CW-1:0]   out_count_q, out_count_n;

    logic            accept_c;
    logic            past_end_c;
    logic            do_flush;
    logic            do_read;
    logic            flush_end;

    assign accept_c   = out_valid_q && out_ready;
    // 17-bit compare so an END_ADDR of FFFF terminates instead of wrapping
    assign past_end_c = addr_q > AW'(END_ADDR);

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= AW'(START_ADDR);
            byte_q      <= '0;
            run_val_q   <= '0;
            run_len_q   <= '0;
            final_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= START_ADDR;
            mem_rd_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            byte_q      <= byte_n;
            run_val_q   <= run_val_n;
            run_len_q   <= run_len_n;
            final_q     <= final_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            mem_addr_q  <= mem_addr_n;
            mem_rd_q    <= mem_rd_n;
            out_data_q  <= out_data_n;
            out_valid_q <= out_valid_n;
            out_count_q <= out_count_n;
        end
    end

    // Next-state, run tracking and stream byte selection
    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        byte_n      = byte_q;
        run_val_n   = run_val_q;
        run_len_n   = run_len_q;
        final_n     = final_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_rd_n    = 1'b0;
        out_data_n  = out_data_q;
        out_valid_n = out_valid_q;
        out_count_n = out_count_q;
        do_flush    = 1'b0;
        do_read     = 1'b0;
        flush_end   = 1'b0;

        if (accept_c) begin
            out_count_n = out_count_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_n      = AW'(START_ADDR);
                    out_count_n = '0;
                    run_len_n   = '0;
                    final_n     = 1'b0;
                    busy_n      = 1'b1;
                    do_read     = 1'b1;
                end
            end
            READ: begin
                state_n = WAIT;
            end
            WAIT: begin
                byte_n  = mem_din;
                addr_n  = addr_q + AW'(1);
                state_n = CMP;
            end
            CMP: begin
                if (run_len_q == '0) begin
                    run_val_n = byte_q;
                    run_len_n = DW'(1);
                end else if ((byte_q == run_val_q) && (run_len_q != RUN_MAX)) begin
                    run_len_n = run_len_q + DW'(1);
                end else begin
                    // byte_q is held and becomes the new run once this flush ends
                    final_n  = 1'b0;
                    do_flush = 1'b1;
                end
                if (!do_flush) begin
                    if (past_end_c) begin
                        final_n  = 1'b1;
                        do_flush = 1'b1;
                    end else begin
                        do_read = 1'b1;
                    end
                end
            end
            FLUSH_LIT: begin
                if (accept_c) begin
                    if (run_len_q == DW'(1)) begin
                        flush_end = 1'b1;
                    end else begin
                        run_len_n = run_len_q - DW'(1);
                    end
                end
            end
            FLUSH_ESC0: begin
                if (accept_c) begin
                    out_data_n = run_len_q;
                    state_n    = FLUSH_ESC1;
                end
            end
            FLUSH_ESC1: begin
                if (accept_c) begin
                    out_data_n = run_val_q;
                    state_n    = FLUSH_ESC2;
                end
            end
            FLUSH_ESC2: begin
                if (accept_c) begin
                    flush_end = 1'b1;
                end
            end
            TERM0: begin
                if (accept_c) begin
                    out_data_n = 8'h00;
                    state_n    = TERM1;
                end
            end
            TERM1: begin
                if (accept_c) begin
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Finished emitting a run: either terminate or start the held byte as a new run
        if (flush_end) begin
            if (final_q) begin
                out_data_n  = ESC;
                out_valid_n = 1'b1;
                state_n     = TERM0;
            end else begin
                run_val_n = byte_q;
                run_len_n = DW'(1);
                if (past_end_c) begin
                    final_n  = 1'b1;
                    do_flush = 1'b1;
                end else begin
                    do_read = 1'b1;
                end
            end
        end

        // Present the first byte of a run: escape for ED or long runs, literal otherwise
        if (do_flush) begin
            out_valid_n = 1'b1;
            if ((run_val_n == ESC) || (32'(run_len_n) >= MIN_RUN)) begin
                out_data_n = ESC;
                state_n    = FLUSH_ESC0;
            end else begin
                out_data_n = run_val_n;
                state_n    = FLUSH_LIT;
            end
        end

        // Issue a read only when no stream byte is pending
        if (do_read) begin
            out_valid_n = 1'b0;
            mem_rd_n    = 1'b1;
            mem_addr_n  = addr_n[MW-1:0];
            state_n     = READ;
        end
    end

endmodule

// File: tb/tb_ace_rle_encoder.sv
// tb_ace_rle_encoder: directed and randomized dumps checked against a run-length
// reference model and a .ACE decoder round trip.
module tb_ace_rle_encoder;

    typedef logic [7:0] bq_t[$];

    localparam logic [15:0] S_START = 16'h2000;
    localparam logic [15:0] S_END   = 16'h2003;
    localparam logic [15:0] L_START = 16'hFE00;
    localparam logic [15:0] L_END   = 16'hFFFF;
    localparam int L_LEN   = 512;
    localparam int MIN_RUN = 3;
    localparam int BUDGET  = 20000;

    logic clk_sys   = 1'b0;
    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic sel       = 1'b0;
    logic out_ready = 1'b1;
    logic bp_en     = 1'b0;

    logic [7:0] mem [0:65535];

    logic        busy_s, done_s, mem_rd_s, out_valid_s;
    logic [15:0] mem_addr_s;
    logic [7:0]  mem_din_s = 8'h00;
    logic [7:0]  out_data_s;
    logic [16:0] out_count_s;

    logic        busy_l, done_l, mem_rd_l, out_valid_l;
    logic [15:0] mem_addr_l;
    logic [7:0]  mem_din_l = 8'h00;
    logic [7:0]  out_data_l;
    logic [16:0] out_count_l;

    logic start_s, start_l;
    logic o_valid, o_busy, o_done;
    logic [7:0]  o_data;
    logic [16:0] o_count;
    logic [15:0] o_addr;

    assign start_s = start & ~sel;
    assign start_l = start & sel;
    assign o_valid = sel ? out_valid_l : out_valid_s;
    assign o_busy  = sel ? busy_l      : busy_s;
    assign o_done  = sel ? done_l      : done_s;
    assign o_data  = sel ? out_data_l  : out_data_s;
    assign o_count = sel ? out_count_l : out_count_s;
    assign o_addr  = sel ? mem_addr_l  : mem_addr_s;

    ace_rle_encoder #(.START_ADDR(S_START), .END_ADDR(S_END)) dut_s (
        .clk_sys(clk_sys), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_addr(mem_addr_s), .mem_rd(mem_rd_s), .mem_din(mem_din_s),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_count(out_count_s)
    );

    ace_rle_encoder #(.START_ADDR(L_START), .END_ADDR(L_END)) dut_l (
        .clk_sys(clk_sys), .reset(reset), .start(start_l), .busy(busy_l), .done(done_l),
        .mem_addr(mem_addr_l), .mem_rd(mem_rd_l), .mem_din(mem_din_l),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_count(out_count_l)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM with one-cycle read latency
    always @(posedge clk_sys) if (mem_rd_s) mem_din_s <= mem[mem_addr_s];
    always @(posedge clk_sys) if (mem_rd_l) mem_din_l <= mem[mem_addr_l];

    // Consumer ready, optionally random
    initial forever begin
        @(posedge clk_sys);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: collects accepted bytes, counts done pulses and stall violations
    bq_t got;
    int  done_seen = 0;
    int  stall_bad = 0;
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;
    initial forever begin
        @(negedge clk_sys);
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held && (!o_valid || o_data !== held_data)) stall_bad++;
            if (o_done) done_seen++;
            if (o_valid && out_ready) begin
                got.push_back(o_data);
                held = 1'b0;
            end else if (o_valid) begin
                held      = 1'b1;
                held_data = o_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Greedy run splitting: runs capped at 255, ED or long runs escaped
    function automatic bq_t rle_model(input bq_t src);
        bq_t r;
        int  i = 0;
        int  l;
        while (i < src.size()) begin
            l = 1;
            while (i + l < src.size() && src[i + l] == src[i] && l < 255) l++;
            if (src[i] == 8'hED || l >= MIN_RUN) begin
                r.push_back(8'hED);
                r.push_back(8'(l));
                r.push_back(src[i]);
            end else begin
                for (int k = 0; k < l; k++) r.push_back(src[i]);
            end
            i += l;
        end
        r.push_back(8'hED);
        r.push_back(8'h00);
        return r;
    endfunction

    // .ACE loader behaviour
    function automatic bq_t ace_decode(input bq_t s);
        bq_t r;
        int  i = 0;
        while (i < s.size()) begin
            if (s[i] == 8'hED) begin
                if (i + 2 >= s.size() || s[i + 1] == 8'h00) break;
                repeat (int'(s[i + 1])) r.push_back(s[i + 2]);
                i += 3;
            end else begin
                r.push_back(s[i]);
                i++;
            end
        end
        return r;
    endfunction

    function automatic bq_t gen_region(input int n);
        bq_t        r;
        logic [7:0] v;
        int         l;
        while (r.size() < n) begin
            case ($urandom_range(0, 4))
                0:       v = 8'hED;
                1:       v = 8'h00;
                2:       v = 8'h55;
                default: v = 8'($urandom);
            endcase
            l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 300))
                                            : int'($urandom_range(1, 4));
            for (int k = 0; k < l && r.size() < n; k++) r.push_back(v);
        end
        r[n - 3] = 8'h76;
        r[n - 2] = 8'h77;
        r[n - 1] = 8'h77;
        return r;
    endfunction

    task automatic load_region(input logic which, input bq_t src);
        for (int i = 0; i < src.size(); i++)
            mem[16'((which ? int'(L_START) : int'(S_START)) + i)] = src[i];
    endtask

    task automatic dump_check(input logic which, input bq_t src, input bq_t exp,
                              input string tag, input int busy_kick);
        bq_t s;
        bq_t rt;
        int  base;
        int  d0;
        int  sb0;
        logic fin;
        load_region(which, src);
        sel = which;
        @(posedge clk_sys);
        #1;
        base  = got.size();
        d0    = done_seen;
        sb0   = stall_bad;
        start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        fin = 1'b0;
        for (int c = 0; c < BUDGET && !fin; c++) begin
            @(posedge clk_sys);
            #1;
            start = (busy_kick != 0) && (c == busy_kick);
            if (done_seen != d0) fin = 1'b1;
        end
        start = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'd1);
        repeat (3) @(posedge clk_sys);
        #1;
        for (int i = base; i < got.size(); i++) s.push_back(got[i]);
        check({tag, "_len"}, 32'(s.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < s.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(s[i]), 32'(exp[i]));
        check({tag, "_count"}, 32'(o_count), 32'(exp.size()));
        check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        check({tag, "_stall_hold"}, 32'(stall_bad - sb0), 32'd0);
        rt = ace_decode(s);
        check({tag, "_rt_len"}, 32'(rt.size()), 32'(src.size()));
        for (int i = 0; i < src.size() && i < rt.size(); i++)
            check($sformatf("%s_rt%0d", tag, i), 32'(rt[i]), 32'(src[i]));
    endtask

    initial begin
        bq_t  src;
        bq_t  e;
        int   n0;
        int   d0;
        logic seen;

        #12;
        check("rst_busy_s", 32'(busy_s), 32'd0);
        check("rst_done_s", 32'(done_s), 32'd0);
        check("rst_mem_rd_s", 32'(mem_rd_s), 32'd0);
        check("rst_mem_addr_s", 32'(mem_addr_s), 32'h2000);
        check("rst_mem_addr_l", 32'(mem_addr_l), 32'hFE00);
        check("rst_valid_s", 32'(out_valid_s), 32'd0);
        check("rst_data_s", 32'(out_data_s), 32'd0);
        check("rst_count_l", 32'(out_count_l), 32'd0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;

        src = '{8'h00, 8'h00, 8'h00, 8'h00};
        e   = '{8'hED, 8'h04, 8'h00, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "zeros", 0);
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        e   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "literals", 0);
        src = '{8'hED, 8'h11, 8'h22, 8'h33};
        e   = '{8'hED, 8'h01, 8'hED, 8'h11, 8'h22, 8'h33, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "lone_ed", 0);
        src = '{8'hAA, 8'hAA, 8'h55, 8'h66};
        e   = '{8'hAA, 8'hAA, 8'h55, 8'h66, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "short_run", 0);
        src = '{8'h77, 8'h77, 8'h77, 8'h66};
        e   = '{8'hED, 8'h03, 8'h77, 8'h66, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "min_run", 0);
        src = '{8'hED, 8'hED, 8'h01, 8'h01};
        e   = '{8'hED, 8'h02, 8'hED, 8'h01, 8'h01, 8'hED, 8'h00};
        dump_check(1'b0, src, e, "ed_pair", 0);

        src = {};
        for (int i = 0; i < L_LEN; i++) src.push_back(i < 300 ? 8'h55 : 8'h00);
        e = '{8'hED, 8'hFF, 8'h55, 8'hED, 8'h2D, 8'h55, 8'hED, 8'hD4, 8'h00, 8'hED, 8'h00};
        dump_check(1'b1, src, e, "long_run", 0);
        check("no_wrap_addr", 32'(o_addr), 32'hFFFF);

        src = gen_region(L_LEN);
        dump_check(1'b1, src, rle_model(src), "rand_a", 0);

        bp_en = 1'b1;
        dump_check(1'b1, src, rle_model(src), "rand_a_bp", 0);

        src = gen_region(L_LEN);
        dump_check(1'b1, src, rle_model(src), "rand_b_kick", 100);

        // Abort while a byte is on the stream
        src = gen_region(L_LEN);
        load_region(1'b1, src);
        sel = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clk_sys);
            #1;
            if (c >= 150 && o_valid) seen = 1'b1;
        end
        check("abort_reached_output", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_count", 32'(o_count), 32'd0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        n0 = got.size();
        d0 = done_seen;
        repeat (30) @(posedge clk_sys);
        #1;
        check("abort_no_term", 32'(got.size()), 32'(n0));
        check("abort_no_done", 32'(done_seen), 32'(d0));
        dump_check(1'b1, src, rle_model(src), "after_abort", 0);

        bp_en = 1'b0;
        src = gen_region(L_LEN);
        dump_check(1'b1, src, rle_model(src), "rand_c", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
